// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one-outstanding-read bus master feeding a small FIFO.
// Define IFETCH_PREFETCH_EN for a 2-deep queue that prefetches ahead of the decoder.
module ifetch_queue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc_in,
  input  logic        pc_load,
  output logic        ifetch_req,
  output logic [15:0] ifetch_addr,
  input  logic [15:0] bus_data,
  input  logic        bus_ack,
  output logic [15:0] idc_opc,
  output logic [15:0] opc_pc,
  output logic        opc_valid,
  input  logic        opc_take,
  output logic [1:0]  q_count
);

`ifdef IFETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        primed_q, primed_d;
  logic [15:0] fa_q, fa_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] h_opc_q, h_opc_d;
  logic [15:0] h_pc_q, h_pc_d;
  logic [15:0] t_opc_q, t_opc_d;
  logic [15:0] t_pc_q, t_pc_d;

  logic [15:0] load_pc;
  logic        push;
  logic        pop;

  assign load_pc = {pc_in[15:1], 1'b0};
  assign push    = (state_q == REQ) && bus_ack && !pc_load;
  assign pop     = opc_take && (cnt_q != 2'd0);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    primed_d = primed_q;
    fa_d     = fa_q;
    unique case (state_q)
      IDLE: begin
        // a redirect issues its first read straight away
        if (pc_load) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = load_pc;
        end else if (primed_q && (cnt_q < DEPTH)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fa_q;
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (pc_load) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    if (pc_load) begin
      fa_d     = load_pc;
      primed_d = 1'b1;
    end else if (push) begin
      fa_d = fa_q + 16'd2;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    h_opc_d = h_opc_q;
    h_pc_d  = h_pc_q;
    t_opc_d = t_opc_q;
    t_pc_d  = t_pc_q;
    if (pc_load) begin
      cnt_d   = 2'd0;
      h_opc_d = 16'd0;
      h_pc_d  = 16'd0;
      t_opc_d = 16'd0;
      t_pc_d  = 16'd0;
    end else if (push && pop) begin
      if (cnt_q == 2'd1) begin
        h_opc_d = bus_data;
        h_pc_d  = fa_q;
      end else begin
        h_opc_d = t_opc_q;
        h_pc_d  = t_pc_q;
        t_opc_d = bus_data;
        t_pc_d  = fa_q;
      end
    end else if (pop) begin
      // tail slot is zero when empty, so the head reads 0 once drained
      cnt_d   = cnt_q - 2'd1;
      h_opc_d = t_opc_q;
      h_pc_d  = t_pc_q;
      t_opc_d = 16'd0;
      t_pc_d  = 16'd0;
    end else if (push) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd0) begin
        h_opc_d = bus_data;
        h_pc_d  = fa_q;
      end else begin
        t_opc_d = bus_data;
        t_pc_d  = fa_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      primed_q <= 1'b0;
      fa_q     <= 16'd0;
      req_q    <= 1'b0;
      addr_q   <= 16'd0;
      cnt_q    <= 2'd0;
      h_opc_q  <= 16'd0;
      h_pc_q   <= 16'd0;
      t_opc_q  <= 16'd0;
      t_pc_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      primed_q <= primed_d;
      fa_q     <= fa_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      h_opc_q  <= h_opc_d;
      h_pc_q   <= h_pc_d;
      t_opc_q  <= t_opc_d;
      t_pc_q   <= t_pc_d;
    end
  end

  assign ifetch_req  = req_q;
  assign ifetch_addr = addr_q;
  assign idc_opc     = h_opc_q;
  assign opc_pc      = h_pc_q;
  assign opc_valid   = (cnt_q != 2'd0);
  assign q_count     = cnt_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed bus/redirect stimulus with a
// scoreboard of expected words checked when the decoder takes them.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        ifetch_req;
  logic [15:0] ifetch_addr;
  logic [15:0] bus_data;
  logic        bus_ack;
  logic [15:0] idc_opc;
  logic [15:0] opc_pc;
  logic        opc_valid;
  logic        opc_take;
  logic [1:0]  q_count;

  typedef struct packed {
    logic [15:0] opc;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  ifetch_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_in      (pc_in),
    .pc_load    (pc_load),
    .ifetch_req (ifetch_req),
    .ifetch_addr(ifetch_addr),
    .bus_data   (bus_data),
    .bus_ack    (bus_ack),
    .idc_opc    (idc_opc),
    .opc_pc     (opc_pc),
    .opc_valid  (opc_valid),
    .opc_take   (opc_take),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %o want %o", nm, act, exp);
  endtask

  // scoreboard monitor: compare the head word whenever it is consumed
  always @(negedge clk) begin
    if (reset_n && opc_valid && opc_take) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_empty: got %o want none", idc_opc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("head_opc", idc_opc, e.opc);
        chk("head_pc", opc_pc, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm, input logic [15:0] addr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifetch_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_req"}, {15'd0, seen}, 16'd1);
    chk({nm, "_addr"}, ifetch_addr, addr);
    tick();
  endtask

  task automatic ack(input logic [15:0] d, input logic [15:0] pc,
                     input bit keep);
    bus_data = d;
    bus_ack  = 1'b1;
    if (keep) exp_q.push_back('{opc: d, pc: pc});
    tick();
    bus_ack  = 1'b0;
    bus_data = 16'd0;
  endtask

  task automatic take();
    opc_take = 1'b1;
    tick();
    opc_take = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] pc);
    pc_in   = pc;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", {15'd0, ifetch_req}, 16'd0);
    chk("rst_addr", ifetch_addr, 16'd0);
    chk("rst_cnt", {14'd0, q_count}, 16'd0);
    chk("rst_opc", idc_opc, 16'd0);
    chk("rst_pc", opc_pc, 16'd0);
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    pc_in    = 16'd0;
    pc_load  = 1'b0;
    bus_data = 16'd0;
    bus_ack  = 1'b0;
    opc_take = 1'b0;
    repeat (2) tick();
    do_reset();

    // no fetch before the first redirect
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_req", {15'd0, ifetch_req}, 16'd0);
      chk("idle_valid", {15'd0, opc_valid}, 16'd0);
      tick();
    end

    // address wrap at the top of memory
    redirect(16'o177776);
    @(negedge clk);
    chk("wrap_lat", {15'd0, ifetch_req}, 16'd1);
    chk("wrap_a0", ifetch_addr, 16'o177776);
    tick();
    ack(16'o000001, 16'o177776, 1'b1);
    @(negedge clk);
    chk("wrap_valid", {15'd0, opc_valid}, 16'd1);
    tick();
    take();
    wait_req("wrap_a1", 16'o000000);
    ack(16'o000002, 16'o000000, 1'b1);
    take();
    @(negedge clk);
    chk("drain_opc", idc_opc, 16'd0);
    chk("drain_pc", opc_pc, 16'd0);
    wait_req("wrap_a2", 16'o000002);
    do_reset();

    // first fetch after redirect, bit 0 forced low
    redirect(16'o100001);
    @(negedge clk);
    chk("f0_lat", {15'd0, ifetch_req}, 16'd1);
    chk("f0_addr", ifetch_addr, 16'o100000);
    tick();
    tick();
    ack(16'o012700, 16'o100000, 1'b1);
    @(negedge clk);
    chk("f0_opc", idc_opc, 16'o012700);
    chk("f0_pc", opc_pc, 16'o100000);
    chk("f0_cnt", {14'd0, q_count}, 16'd1);
`ifndef IFETCH_PREFETCH_EN
    tick();
    ack(16'o177777, 16'o0, 1'b0);
    @(negedge clk);
    chk("stray_ack", {14'd0, q_count}, 16'd1);
`endif
    tick();
    take();

    // redirect while waiting on a read: old data must be dropped
    wait_req("f1", 16'o100002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req", {15'd0, ifetch_req}, 16'd1);
      chk("hold_addr", ifetch_addr, 16'o100002);
      tick();
    end
    redirect(16'o001000);
    @(negedge clk);
    chk("drop_req", {15'd0, ifetch_req}, 16'd1);
    chk("drop_addr", ifetch_addr, 16'o100002);
    chk("drop_cnt", {14'd0, q_count}, 16'd0);
    tick();
    ack(16'o111111, 16'o0, 1'b0);
    @(negedge clk);
    chk("drop_empty", {14'd0, q_count}, 16'd0);
    chk("drop_valid", {15'd0, opc_valid}, 16'd0);
    wait_req("redir", 16'o001000);
    ack(16'o000240, 16'o001000, 1'b1);
    @(negedge clk);
    chk("redir_cnt", {14'd0, q_count}, 16'd1);
    tick();
    take();
    do_reset();

    redirect(16'o100000);
`ifdef IFETCH_PREFETCH_EN
    // two reads fill the queue, then fetching stalls
    wait_req("pf0", 16'o100000);
    ack(16'o000100, 16'o100000, 1'b1);
    wait_req("pf1", 16'o100002);
    ack(16'o000101, 16'o100002, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("pf_full_req", {15'd0, ifetch_req}, 16'd0);
      chk("pf_full_cnt", {14'd0, q_count}, 16'd2);
      tick();
    end
    take();
    wait_req("pf2", 16'o100004);
    // push and pop together at one entry
    opc_take = 1'b1;
    ack(16'o000102, 16'o100004, 1'b1);
    opc_take = 1'b0;
    @(negedge clk);
    chk("pp_cnt", {14'd0, q_count}, 16'd1);
    chk("pp_opc", idc_opc, 16'o000102);
    tick();
    take();
`else
    // single-entry queue: no fetch while the word awaits the decoder
    wait_req("sd0", 16'o100000);
    opc_take = 1'b1;
    ack(16'o000100, 16'o100000, 1'b1);
    opc_take = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("sd_full_req", {15'd0, ifetch_req}, 16'd0);
      chk("sd_full_cnt", {14'd0, q_count}, 16'd1);
      tick();
    end
    take();
    wait_req("sd1", 16'o100002);
`endif
    tick();
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_left: got %0d want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port pc_in  input  16  redirect address; bit 0 ignored (forced 0).
REQ-004 SHALL have port pc_load  input  1  redirect strobe; flushes queue, reloads fetch address.
REQ-005 SHALL have port ifetch_req  output  1  bus read request, word access.
REQ-006 SHALL have port ifetch_addr  output  16  bus read address; stable while ifetch_req high.
REQ-007 SHALL have port bus_data  input  16  read data, valid when bus_ack high.
REQ-008 SHALL have port bus_ack  input  1  one-cycle read completion.
REQ-009 SHALL have port idc_opc  output  16  head-of-queue word, driven to the instruction decoder.
REQ-010 SHALL have port opc_pc  output  16  address of head word.
REQ-011 SHALL have port opc_valid  output  1  head word valid.
REQ-012 SHALL have port opc_take  input  1  consumer pops head word; ignored when opc_valid low.
REQ-013 SHALL have port q_count  output  2  number of queued words.

Function
REQ-014 SHALL hold fetch address fa; fa += 2 (mod 2^16) on each accepted bus_ack; 16'o177776 wraps to 0.
REQ-015 SHALL implement FSM IDLE / REQ / DROP; one outstanding bus read maximum.
REQ-016 IDLE -> REQ when primed and q_count < DEPTH and pc_load low; ifetch_req high, ifetch_addr = fa from next cycle.
REQ-017 REQ: ifetch_req held high, ifetch_addr stable until bus_ack; on bus_ack push bus_data with address fa, go IDLE.
REQ-018 REQ with pc_load (with or without bus_ack same cycle): data discarded; with bus_ack -> IDLE, else -> DROP.
REQ-019 DROP: ifetch_req held high with old address; on bus_ack data discarded, -> IDLE; pc_load in DROP only updates fa.
REQ-020 pc_load: queue cleared, fa <= {pc_in[15:1],1'b0}, primed set; pc_load wins over simultaneous opc_take and push.
REQ-021 Push and pop in same cycle: q_count unchanged, order preserved (FIFO).
REQ-022 bus_ack outside REQ/DROP SHALL be ignored.
REQ-023 Latency: pc_load at cycle N in IDLE -> ifetch_req at N+1; bus_ack at M into empty queue -> opc_valid, idc_opc at M+1.
REQ-024 idc_opc / opc_pc SHALL be registered; 0 when opc_valid low.

Reset
REQ-025 reset_n low SHALL asynchronously force: state IDLE, primed 0, fa 0, q_count 0, opc_valid 0, ifetch_req 0, ifetch_addr 0, idc_opc 0, opc_pc 0.
REQ-026 After reset no fetch SHALL start until first pc_load; reset mid-bus-cycle drops request immediately.

Configuration
REQ-027 Macro IFETCH_PREFETCH_EN defined: DEPTH = 2, fetch continues while head word awaits opc_take.
REQ-028 Macro IFETCH_PREFETCH_EN undefined: DEPTH = 1, new fetch only after queue empties; q_count never exceeds 1.

Verification
REQ-029 Reset, no pc_load, 20 cycles -> ifetch_req stays 0, opc_valid 0.
REQ-030 pc_load pc_in=16'o100001, ack data 16'o012700 after 2 cycles -> ifetch_addr 16'o100000, idc_opc 16'o012700, opc_pc 16'o100000, next ifetch_addr 16'o100002.
REQ-031 Prefetch on, opc_take held low -> exactly two reads (o100000, o100002), q_count 2, ifetch_req then stays 0; one take -> third read o100004.
REQ-032 pc_load o001000 while REQ at o100002 waiting 3 cycles -> DROP, ack data discarded, next read o001000, queue empty until its ack.
REQ-033 pc_load o177776, ack twice with take -> addresses o177776 then o000000.
REQ-034 Ack with simultaneous opc_take at q_count 1 -> q_count stays 1, head advances to older-next word.
